uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter among NUM_REQ byte-stream requesters.
- Arbitration is round-robin at message granularity: a granted requester keeps the transmitter until its last byte is accepted or a length cap forces release.
- Sits between on-chip producers (debug, status, echo) and the UART tx_byte/tx_valid/tx_ready interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of the grant index; must equal clog2(NUM_REQ).
- MAX_LEN, 64, maximum bytes per grant before forced release (1..255); 0 disables the cap.
- TAG_BASE, 8'h80, tag byte base value; used only when UART_ARB_TAG_EN is defined.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_byte  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NUM_REQ  qualifies req_byte as final byte of the message
- req_ready  out  NUM_REQ  byte accepted from requester i this cycle
- tx_byte  out  8  byte to UART transmitter
- tx_valid  out  1  byte valid to UART
- tx_ready  in  1  UART idle/accepting
- grant  out  IDX_W  index of current owner
- busy  out  1  a message is in progress

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state=IDLE, grant=0, busy=0, rr_ptr=NUM_REQ-1, byte count=0.
  - tx_valid=0, req_ready=0.
- Handshakes:
  - UART transfer occurs on a cycle with tx_valid && tx_ready.
  - Requester transfer occurs on a cycle with req_valid[i] && req_ready[i].
- States: IDLE, DATA; TAG exists only with the optional feature.
- IDLE:
  - tx_valid=0 and req_ready=0.
  - When any req_valid is high, select the first requester with valid set, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - Register grant, set busy=1 and clear the byte count on the same edge, then go to DATA.
  - Arbitration latency: one cycle from req_valid to grant/busy visible.
- DATA:
  - Pass-through, no data buffering: tx_valid=req_valid[grant] and tx_byte=req_byte[grant].
  - req_ready[grant]=tx_ready; req_ready for all other requesters is 0.
  - On each handshake, increment the byte count (8-bit, saturating).
- Release from DATA to IDLE, on a handshake with:
  - req_last[grant]=1, or
  - MAX_LEN!=0 and the count after increment equals MAX_LEN (forced release; the remainder of the message re-arbitrates).
- On release:
  - rr_ptr<=grant, busy<=0.
  - grant holds its value until the next arbitration.
- Owner deasserts req_valid mid-message: the grant is held and tx_valid stays low; the arbiter never preempts except via MAX_LEN.
- Release and new requests in the same cycle: the new decision is made in IDLE on the next cycle, one idle cycle minimum between messages, using the updated rr_ptr.
- Requests that change while not granted are ignored until IDLE; no requester is starved (round-robin bound: NUM_REQ-1 messages).
- Outputs tx_byte and req_ready are don't-care while tx_valid=0; tx_byte drives 8'h00 in IDLE.
- Async reset mid-message: the arbiter returns immediately to reset values; the partial message is abandoned and requesters must restart.

Optional Feature:
- Macro: UART_ARB_TAG_EN.
- Defined:
  - IDLE goes to TAG instead of DATA after a grant.
  - TAG drives tx_valid=1 and tx_byte=TAG_BASE|grant (zero-extended index); req_ready=0.
  - On tx_ready the arbiter moves to DATA; the tag does not count toward MAX_LEN.
  - A forced release followed by re-grant emits a fresh tag.
- Undefined: no TAG state; the byte stream is the raw concatenation of messages.

Test Plan:
- Single requester 1 sends 3 bytes 8'h41,8'h42,8'h43 (last on third), tx_ready pulsing → tx_byte sequence 41,42,43, grant=1, busy drops the cycle after third handshake.
- All 4 requesters valid continuously, 1-byte messages each, rr_ptr=3 after reset → grant order 0,1,2,3,0.
- Requester 2 granted, drops req_valid for 5 cycles mid-message while requester 0 is valid → grant stays 2, tx_valid=0 for those cycles, requester 0 is served only after req_last from 2.
- MAX_LEN=4, requester 0 streams 10 bytes without last while requester 1 is valid → after 4 bytes grant moves to 1; requester 0 resumes after 1's message.
- Assert reset_n=0 asynchronously mid-DATA → tx_valid, busy and req_ready go 0 immediately and grant=0; after release the next request arbitrates from index 0.
- With UART_ARB_TAG_EN, TAG_BASE=8'h80, requester 3 sends 8'h55 (last) → UART sees 8'h83 then 8'h55.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Optional UART_ARB_TAG_EN: prefix each grant with a tag byte TAG_BASE|grant.
module uart_tx_arbiter #(
    parameter int         NUM_REQ  = 4,
    parameter int         IDX_W    = 2,
    parameter int         MAX_LEN  = 64,
    parameter logic [7:0] TAG_BASE = 8'h80
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_byte,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_byte,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [IDX_W-1:0]     grant,
    output logic                 busy
);

`ifdef UART_ARB_TAG_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, TAG = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1} state_t;
`endif

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             busy_q, busy_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic             sel_valid, sel_last;
    logic [7:0]       sel_byte;
    logic [7:0]       cnt_inc;
    logic             hs, cap_hit, rel;

    // Search starts just past the last owner so every requester is reached within NUM_REQ-1 messages.
    always_comb begin
        int p;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            p = int'(rr_ptr_q) + k;
            if (p >= NUM_REQ) p = p - NUM_REQ;
            if (!arb_found && req_valid[p[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = p[IDX_W-1:0];
            end
        end
    end

    assign sel_valid = req_valid[grant_q];
    assign sel_last  = req_last[grant_q];
    assign sel_byte  = req_byte[{grant_q, 3'b000} +: 8];
    assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign hs        = (state_q == DATA) && sel_valid && tx_ready;
    assign cap_hit   = (MAX_LEN != 0) && (cnt_inc == 8'(MAX_LEN));
    assign rel       = hs && (sel_last || cap_hit);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
            busy_q   <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    busy_d  = 1'b1;
                    cnt_d   = 8'd0;
`ifdef UART_ARB_TAG_EN
                    state_d = TAG;
`else
                    state_d = DATA;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            TAG: begin
                if (tx_ready) state_d = DATA;
            end
`endif
            DATA: begin
                if (hs) cnt_d = cnt_inc;
                if (rel) begin
                    // grant is left alone so observers still see the last owner while idle
                    rr_ptr_d = grant_q;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_valid  = 1'b0;
        tx_byte   = 8'h00;
        req_ready = '0;
        case (state_q)
            DATA: begin
                tx_valid           = sel_valid;
                tx_byte            = sel_byte;
                req_ready[grant_q] = tx_ready;
            end
`ifdef UART_ARB_TAG_EN
            TAG: begin
                tx_valid = 1'b1;
                tx_byte  = TAG_BASE | 8'(grant_q);
            end
`endif
            default: ;
        endcase
    end

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule
